// File: rtl/pdp8_bus_pkg.sv
// Shared types for the PDP-8 pin-bus bridge: bus command codes, nibble selects,
// memory FSM states and the queued memory command record.
package pdp8_bus_pkg;

    localparam int WORD_W = 12;
    localparam int NIB_W  = 4;

    // cpu_out[6:5] selects which nibble of the read buffer goes back to the core
    localparam logic [1:0] NIB_SEL_HI   = 2'b00;
    localparam logic [1:0] NIB_SEL_MID  = 2'b01;
    localparam logic [1:0] NIB_SEL_LO   = 2'b10;
    localparam logic [1:0] NIB_SEL_NONE = 2'b11;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_ADDR_HI,
        CMD_ADDR_LO,
        CMD_IOSEL,
        CMD_WLO,
        CMD_WHI,
        CMD_COMMIT
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R
    } mem_state_e;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_cmd_t;

    function automatic cmd_e decode_cmd(input logic [3:0] code_hi);
        cmd_e c;
        casez (code_hi)
            4'b11??: c = CMD_ADDR_HI;
            4'b10??: c = CMD_ADDR_LO;
            4'b011?: c = CMD_IOSEL;
            4'b0001: c = CMD_WLO;
            4'b0011: c = CMD_WHI;
            4'b0101: c = CMD_COMMIT;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pdp8_cmd_fifo.sv
// Small power-of-two command queue; a push into a full queue is still accepted
// when a pop frees the head slot in the same cycle.
module pdp8_cmd_fifo
    import pdp8_bus_pkg::*;
#(
    parameter int CMD_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  mem_cmd_t push_cmd_i,
    input  logic     pop_i,
    output mem_cmd_t head_o,
    output logic     push_ok_o,
    output logic     drop_o,
    output logic     empty_o,
    output logic     full_o,
    output logic     multi_o
);
    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = $clog2(CMD_DEPTH + 1);

    mem_cmd_t      slot_q [CMD_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(CMD_DEPTH));
    assign multi_o   = (count_q > CW'(1));
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok_o = push_i && (!full_o || pop_ok);
    assign drop_o    = push_i && !push_ok_o;
    assign head_o    = slot_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok_o) begin
            slot_q[wr_ptr_q] <= push_cmd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_o) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok_o, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pdp8_bus_bridge.sv
// Bridge from the PDP-8 multiplexed 8-bit pin bus to a req/gnt/rvalid memory
// port and a bank of I/O channels, with a nibble-wide read-back buffer.
module pdp8_bus_bridge
    import pdp8_bus_pkg::*;
#(
    parameter int N_IO      = 4,
    parameter int CMD_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             cpu_out,
    output logic [NIB_W-1:0]       cpu_din,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WORD_W-1:0]      mem_addr,
    output logic [WORD_W-1:0]      mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [WORD_W-1:0]      mem_rdata,
    output logic [N_IO-1:0]        io_wr,
    output logic [WORD_W-1:0]      io_wdata,
    input  logic [WORD_W*N_IO-1:0] io_rdata,
    output logic [4:0]             io_sel,
    output logic                   rd_valid,
    output logic                   err_ovf
);
    localparam int RPW = $clog2(CMD_DEPTH + 2);

    logic [7:0]        cpu_prev_q;
    logic              io_q, io_d;
    logic [4:0]        io_sel_q, io_sel_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [7:0]        tmp_q, tmp_d;
    logic [WORD_W-1:0] rd_word_q, rd_word_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_ovf_q;
    logic [N_IO-1:0]   io_wr_q, io_wr_d;
    logic [WORD_W-1:0] io_wdata_q, io_wdata_d;
    logic              fresh_q, fresh_d;
    logic [RPW-1:0]    rd_pend_q, rd_pend_d;
    mem_state_e        state_q;
    logic              mem_req_q;

    cmd_e              cmd;
    logic [WORD_W-1:0] commit_word, io_word;
    logic              push, pop, push_ok, drop, rv_take, push_rd;
    mem_cmd_t          push_cmd, head;
    logic              fifo_empty, fifo_full, fifo_multi;

    assign cmd         = (cpu_out != cpu_prev_q) ? decode_cmd(cpu_out[7:4]) : CMD_NONE;
    assign commit_word = {cpu_out[3:0], tmp_q};
    assign push        = (cmd == CMD_ADDR_LO) || ((cmd == CMD_COMMIT) && !io_q);
    assign pop         = mem_req_q && mem_gnt;
    assign rv_take     = (state_q == ST_WAIT_R) && mem_rvalid;
    assign push_rd     = push_ok && !push_cmd.we;

    always_comb begin
        push_cmd.we    = (cmd == CMD_COMMIT);
        push_cmd.addr  = (cmd == CMD_ADDR_LO) ? {addr_q[11:6], cpu_out[5:0]} : addr_q;
        push_cmd.wdata = (cmd == CMD_COMMIT) ? commit_word : '0;
    end

    always_comb begin
        io_word = '0;
        for (int k = 0; k < N_IO; k++) begin
            if (cpu_out[4:0] == 5'(k)) begin
                io_word = io_rdata[k*WORD_W +: WORD_W];
            end
        end
    end

    pdp8_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_cmd_i (push_cmd),
        .pop_i      (pop),
        .head_o     (head),
        .push_ok_o  (push_ok),
        .drop_o     (drop),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .multi_o    (fifo_multi)
    );

    // A bus command in the same cycle as returning read data is the newer intent and wins.
    always_comb begin
        addr_d     = addr_q;
        io_d       = io_q;
        io_sel_d   = io_sel_q;
        tmp_d      = tmp_q;
        rd_word_d  = rd_word_q;
        rd_valid_d = rd_valid_q;
        io_wr_d    = '0;
        io_wdata_d = io_wdata_q;
        if (rv_take) begin
            rd_word_d  = mem_rdata;
            rd_valid_d = fresh_q && (rd_pend_q == RPW'(1));
        end
        case (cmd)
            CMD_ADDR_HI: begin
                addr_d[11:6] = cpu_out[5:0];
                io_d         = 1'b0;
                rd_valid_d   = 1'b0;
            end
            CMD_ADDR_LO: begin
                addr_d[5:0] = cpu_out[5:0];
                io_d        = 1'b0;
                rd_valid_d  = 1'b0;
            end
            CMD_IOSEL: begin
                io_d       = 1'b1;
                io_sel_d   = cpu_out[4:0];
                rd_word_d  = io_word;
                rd_valid_d = 1'b1;
            end
            CMD_WLO: tmp_d[3:0] = cpu_out[3:0];
            CMD_WHI: tmp_d[7:4] = cpu_out[3:0];
            CMD_COMMIT: begin
                if (io_q) begin
                    io_wdata_d = commit_word;
                    for (int k = 0; k < N_IO; k++) begin
                        io_wr_d[k] = (io_sel_q == 5'(k));
                    end
                end else if (push_ok && rd_valid_d) begin
                    rd_word_d = commit_word;
                end
            end
            default: ;
        endcase
    end

    // Read data is only trusted if it belongs to the newest read and no address
    // change or write to the current address was issued behind it.
    always_comb begin
        fresh_d = fresh_q;
        if (push_rd) begin
            fresh_d = 1'b1;
        end else if (cmd == CMD_ADDR_HI || cmd == CMD_ADDR_LO || push_ok) begin
            fresh_d = 1'b0;
        end
        rd_pend_d = rd_pend_q;
        case ({push_rd, rv_take})
            2'b10:   rd_pend_d = rd_pend_q + 1'b1;
            2'b01:   rd_pend_d = rd_pend_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_prev_q <= '0;
            io_q       <= 1'b0;
            io_sel_q   <= '0;
            addr_q     <= '0;
            tmp_q      <= '0;
            rd_word_q  <= '0;
            rd_valid_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            io_wr_q    <= '0;
            io_wdata_q <= '0;
            fresh_q    <= 1'b0;
            rd_pend_q  <= '0;
        end else begin
            cpu_prev_q <= cpu_out;
            io_q       <= io_d;
            io_sel_q   <= io_sel_d;
            addr_q     <= addr_d;
            tmp_q      <= tmp_d;
            rd_word_q  <= rd_word_d;
            rd_valid_q <= rd_valid_d;
            err_ovf_q  <= err_ovf_q | drop;
            io_wr_q    <= io_wr_d;
            io_wdata_q <= io_wdata_d;
            fresh_q    <= fresh_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // push_ok lets the FSM request in the cycle right after the push edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty || push_ok) begin
                        state_q   <= ST_REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        if (!head.we) begin
                            state_q   <= ST_WAIT_R;
                            mem_req_q <= 1'b0;
                        end else if (!(fifo_multi || push_ok)) begin
                            state_q   <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (mem_rvalid) begin
                        if (!fifo_empty || push_ok) begin
                            state_q   <= ST_REQ;
                            mem_req_q <= 1'b1;
                        end else begin
                            state_q   <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q & head.we;
    assign mem_addr  = mem_req_q ? head.addr : '0;
    assign mem_wdata = mem_req_q ? head.wdata : '0;
    assign io_wr     = io_wr_q;
    assign io_wdata  = io_wdata_q;
    assign io_sel    = io_sel_q;
    assign rd_valid  = rd_valid_q;
    assign err_ovf   = err_ovf_q;

    always_comb begin
        cpu_din = '0;
        if (!cpu_out[7]) begin
            case (cpu_out[6:5])
                NIB_SEL_HI:  cpu_din = rd_word_q[11:8];
                NIB_SEL_MID: cpu_din = rd_word_q[7:4];
                NIB_SEL_LO:  cpu_din = rd_word_q[3:0];
                default:     cpu_din = '0;
            endcase
        end
    end

endmodule

// File: doc/pdp8_bus_bridge.md
# pdp8_bus_bridge

Synthesizable bridge between the PDP-8 core's 8-bit multiplexed pin bus and a wide synchronous memory port plus a bank of I/O device channels. It decodes address-half, nibble-write, commit and I/O-select bus codes, and queues memory commands in a small FIFO behind a req/gnt/rvalid handshake. It holds a read buffer that the core reads back one nibble at a time on `cpu_din`. It sits on-chip next to the core and replaces the behavioural latch/SRAM glue used in simulation.

## Interface
- `N_IO`, 4: number of I/O channels, 1..32.
- `CMD_DEPTH`, 2: command FIFO depth, power of two, ≥2.
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `cpu_out`  in  8  core pin outputs
- `cpu_din`  out  4  nibble returned to core inputs [7:4]
- `mem_req`  out  1  request valid, held until granted
- `mem_we`  out  1  1 = write, 0 = read; valid with `mem_req`
- `mem_addr`  out  12  word address
- `mem_wdata`  out  12  write data
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid, ≥1 cycle after read grant
- `mem_rdata`  in  12  read data
- `io_wr`  out  N_IO  one-hot write strobe, 1 cycle
- `io_wdata`  out  12  I/O write data
- `io_rdata`  in  12*N_IO  channel k at [12k+11:12k]
- `io_sel`  out  5  current I/O channel select
- `rd_valid`  out  1  read buffer holds data for the current address/channel
- `err_ovf`  out  1  sticky: command dropped because the FIFO was full

## Operation
- **Command fire:** a command fires when `cpu_out` differs from its previous-cycle registered copy. Identical consecutive values are one command, because the core passes through a non-command code between commands.
- **Decode of fired `cpu_out`:**
  - `11pppppp` ADDR_HI: addr[11:6]=p; io=0; rd_valid=0.
  - `10pppppp` ADDR_LO: addr[5:0]=p; io=0; rd_valid=0; push read {addr[11:6],p}.
  - `011sssss` IOSEL: io=1; io_sel=s; rd_word = io_rdata[s] if s<N_IO, else 0; rd_valid=1.
  - `0001dddd` WLO: tmp[3:0]=d.
  - `0011dddd` WHI: tmp[7:4]=d.
  - `0101dddd` COMMIT: word={d,tmp}.
    - io=1: pulse io_wr[io_sel] with io_wdata=word, no strobe if io_sel≥N_IO.
    - io=0: push write (addr, word).
  - All other codes: no action.
- **Read-back (combinational):** when cpu_out[7]=0, `cpu_din` selects from rd_word by cpu_out[6:5]: 00→[11:8], 01→[7:4], 10→[3:0], 11→0. When cpu_out[7]=1, `cpu_din`=0.
- **Write forwarding:** a write pushed while io=0 and rd_valid=1 to the current addr updates rd_word=word at the push edge.
- **FIFO:** holds {we, addr, wdata}.
  - Push while full is dropped and sets err_ovf; simultaneous pop frees a slot first.
  - FIFO order is preserved; a read never overtakes an earlier write.
- **Memory FSM:**
  - IDLE: FIFO non-empty → REQ.
  - REQ: mem_req=1 with head fields. On gnt: pop; write → IDLE (or stay in REQ if the FIFO is still non-empty); read → WAIT_R.
  - WAIT_R: on rvalid → rd_word=mem_rdata; rd_valid=1 only if no ADDR_HI/ADDR_LO fired since the read was pushed; → IDLE/REQ.
- **Reset:** all outputs 0 and all state 0 (io, io_sel, addr, tmp, rd_word, rd_valid, err_ovf); FIFO empty; FSM IDLE. Applies mid-transaction: mem_req drops the cycle after reset is sampled, and rvalid arriving in/after reset is ignored.

## Timing
- ADDR_LO fired at edge t with an empty FIFO and FSM IDLE → mem_req high from t+1.
- gnt at t+1 edge → WAIT_R; rvalid sampled at edge r → rd_word/cpu_din updated in cycle r+1.
- IOSEL at t → rd_word, rd_valid and io_sel visible from t+1.
- COMMIT(io) at t → io_wr high during cycle t+1 only.
- `cpu_din` has zero latency from `cpu_out`; no other combinational input→output paths.
- err_ovf clears only on reset.

## Structure
- Package `pdp8_bus_pkg`:
  - command code enum decoded from cpu_out[7:4];
  - nibble-select constants;
  - FSM state enum;
  - `mem_cmd_t` struct {we, addr[11:0], wdata[11:0]};
  - width constants WORD_W=12, NIB_W=4.
- Sub-module `pdp8_cmd_fifo`: parametrised by CMD_DEPTH; push/pop/full/empty; same-cycle push+pop when full.

## Test plan
- ADDR_HI 0x05, ADDR_LO 0x21 (addr 0x161), memory returns 0xABC at latency 3 → mem_addr=0x161, mem_we=0; cpu_out[6:5]=00/01/10 give cpu_din 0xA/0xB/0xC; rd_valid=1.
- WLO 0x4, WHI 0x3, COMMIT 0x7 at addr 0x161 → write mem_addr 0x161, wdata 0x734; rd_word forwards to 0x734.
- IOSEL 2 with io_rdata[2]=0x5A5, then WLO 1, WHI 0, COMMIT F → nibbles 5/A/5; io_wr=4'b0100 for one cycle with io_wdata=0xF01; no mem_req; IOSEL 9 (N_IO=4) → rd_word 0, no strobe.
- mem_gnt held 0; fire ADDR_LO, COMMIT, ADDR_LO → third command dropped, err_ovf=1; release gnt → first two issued in order.
- rst_n low during WAIT_R with rvalid arriving next cycle → mem_req=0, rd_word=0, rd_valid=0; FIFO empty.
- ADDR_LO, then ADDR_HI before rvalid → data written to rd_word but rd_valid stays 0.
